// File: rtl/icache_pkg.sv
// icache_pkg
//   Shared types and constants for the instruction-fetch refill controller
//   and the direct-mapped icache it serves (16 lines x 1 word).
//   - ADDR_W / WORD_W : word-address and data widths
//   - LINES / INDEX_W / TAG_W : icache geometry (index = addr[3:0], tag = addr[29:4])
//   - refill_state_t  : refill controller FSM states
//   - in_window()     : uncached-window match on a word address
package icache_pkg;

    localparam int ADDR_W  = 30;
    localparam int WORD_W  = 32;
    localparam int LINES   = 16;
    localparam int INDEX_W = 4;
    localparam int TAG_W   = ADDR_W - INDEX_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        FILL     = 3'd4,
        RESP     = 3'd5
    } refill_state_t;

    // The window is defined on byte addresses, so re-append the two
    // dropped low bits before masking.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [31:0]       base,
                                       input logic [31:0]       mask);
        return (({addr, 2'b00} & mask) == base);
    endfunction

endpackage

// File: rtl/icache_refill.sv
// icache_refill
//   Fetch-side controller between the IFU and a direct-mapped icache.
//   Takes one fetch at a time, looks it up in the icache, and on a miss reads
//   the word from memory, writes it into the icache (FILL) and returns it.
//   Fetches inside the uncached window skip lookup and fill entirely.
//
//   Handshakes: every valid/ready pair transfers on a rising clock edge where
//   both are high; a source holds valid and its payload stable until that
//   edge. The one exception is mem_rsp_valid, which has no ready and is
//   always taken in MEM_WAIT.
//
// Ports
//   clock, reset                 : clock, synchronous active-high reset
//   ifu_req_valid/ready/addr     : fetch request (word address); ready only in IDLE
//   ifu_rsp_valid/ready/data/err : instruction response; data is 0 when err
//   cache_addr                   : icache lookup/fill address (always addr_q)
//   cache_is_hit, cache_rdata    : icache lookup result, combinational on cache_addr
//   cache_wen, cache_wdata       : icache fill port, strobed only in FILL
//   mem_req_valid/ready/addr     : memory read request (byte address)
//   mem_rsp_valid/data/err       : memory read response
//   hit_cnt, miss_cnt            : wrapping lookup counters (uncached fetches excluded)
module icache_refill
    import icache_pkg::*;
#(
    parameter logic [31:0] UNC_BASE = 32'h1000_0000,
    parameter logic [31:0] UNC_MASK = 32'hF000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [WORD_W-1:0] ifu_rsp_data,
    output logic              ifu_rsp_err,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_is_hit,
    input  logic [WORD_W-1:0] cache_rdata,
    output logic              cache_wen,
    output logic [WORD_W-1:0] cache_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [WORD_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    refill_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              unc_q;
    logic [WORD_W-1:0] data_q;
    logic              err_q;
    logic              req_unc;
    logic              lookup_hit;
    logic              lookup_miss;
    // Set when reset cuts off a memory read that the bus already accepted;
    // the orphaned response may still arrive later and is simply dropped.
    logic              stale_q;

    assign req_unc     = in_window(ifu_req_addr, UNC_BASE, UNC_MASK);
    assign lookup_hit  = (state_q == LOOKUP) &&  cache_is_hit;
    assign lookup_miss = (state_q == LOOKUP) && !cache_is_hit;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        mem_req_valid = 1'b0;
        cache_wen     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ifu_req_ready = 1'b1;
                if (ifu_req_valid) begin
                    state_d = req_unc ? MEM_REQ : LOOKUP;
                end
            end
            LOOKUP: begin
                state_d = cache_is_hit ? RESP : MEM_REQ;
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // Errored and uncached words never reach the icache.
                if (mem_rsp_valid) begin
                    state_d = (unc_q || mem_rsp_err) ? RESP : FILL;
                end
            end
            FILL: begin
                cache_wen = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                ifu_rsp_valid = 1'b1;
                if (ifu_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            unc_q  <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && ifu_req_valid) begin
                addr_q <= ifu_req_addr;
                unc_q  <= req_unc;
            end
            if (lookup_hit) begin
                data_q <= cache_rdata;
                err_q  <= 1'b0;
            end
            if (state_q == MEM_WAIT && mem_rsp_valid) begin
                data_q <= mem_rsp_err ? '0 : mem_rsp_data;
                err_q  <= mem_rsp_err;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_cnt <= '0;
        end else if (lookup_hit) begin
            hit_cnt <= hit_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            miss_cnt <= '0;
        end else if (lookup_miss) begin
            miss_cnt <= miss_cnt + 32'd1;
        end
    end

    // Deliberately not cleared by reset: it remembers what reset interrupted.
    always_ff @(posedge clock) begin
        if (reset) begin
            stale_q <= (state_q == MEM_WAIT)
                    || (state_q == MEM_REQ && mem_req_ready)
                    || (stale_q && !mem_rsp_valid);
        end else if (mem_rsp_valid) begin
            stale_q <= 1'b0;
        end
    end

    assign cache_addr   = addr_q;
    assign cache_wdata  = data_q;
    assign mem_req_addr = {addr_q, 2'b00};
    assign ifu_rsp_data = data_q;
    assign ifu_rsp_err  = err_q;

    // A memory response only belongs in MEM_WAIT, or is the tail of a read
    // that was in flight when reset hit.
    a_rsp_in_wait: assert property (@(posedge clock) disable iff (reset)
        mem_rsp_valid |-> (state_q == MEM_WAIT || stale_q));

    a_req_held: assert property (@(posedge clock) disable iff (reset)
        (!$past(reset) && $past(mem_req_valid && !mem_req_ready))
        |-> (mem_req_valid && $stable(mem_req_addr)));

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;
    import icache_pkg::*;

    // ------------------------------------------------------ clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic              ifu_req_valid = 1'b0;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr  = '0;
    logic              ifu_rsp_valid;
    logic              ifu_rsp_ready = 1'b0;
    logic [WORD_W-1:0] ifu_rsp_data;
    logic              ifu_rsp_err;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_is_hit;
    logic [WORD_W-1:0] cache_rdata;
    logic              cache_wen;
    logic [WORD_W-1:0] cache_wdata;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [31:0]       mem_req_addr;
    logic              mem_rsp_valid = 1'b0;
    logic [WORD_W-1:0] mem_rsp_data  = '0;
    logic              mem_rsp_err   = 1'b0;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    icache_refill dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .cache_addr(cache_addr), .cache_is_hit(cache_is_hit), .cache_rdata(cache_rdata),
        .cache_wen(cache_wen), .cache_wdata(cache_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // ---------------------------------------------------- result counters
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------- icache (environment side)
    // Behaves like the real icache: filled only by the DUT's wen strobe.
    logic              env_valid [LINES] = '{default: 1'b0};
    logic [TAG_W-1:0]  env_tag   [LINES] = '{default: '0};
    logic [WORD_W-1:0] env_data  [LINES] = '{default: '0};

    assign cache_is_hit = env_valid[cache_addr[INDEX_W-1:0]]
                       && (env_tag[cache_addr[INDEX_W-1:0]] == cache_addr[ADDR_W-1:INDEX_W]);
    assign cache_rdata  = env_data[cache_addr[INDEX_W-1:0]];

    always @(posedge clock) begin
        if (cache_wen) begin
            env_valid[cache_addr[INDEX_W-1:0]] <= 1'b1;
            env_tag[cache_addr[INDEX_W-1:0]]   <= cache_addr[ADDR_W-1:INDEX_W];
            env_data[cache_addr[INDEX_W-1:0]]  <= cache_wdata;
        end
    end

    // ------------------------------------------------------ memory image
    logic [31:0] mem_img [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] ba);
        if (mem_img.exists(ba)) return mem_img[ba];
        return (ba * 32'd2654435761) ^ 32'h0BAD_F00D;
    endfunction

    int cfg_req_wait = 0;
    int cfg_rsp_wait = 0;
    bit cfg_err      = 1'b0;

    // Memory responder: serves any request it sees, with the configured waits.
    initial begin : mem_proc
        forever begin
            @(posedge clock); #1;
            if (mem_req_valid) begin
                logic [31:0] ba;
                int          rw;
                bit          er;
                ba = mem_req_addr;
                rw = cfg_rsp_wait;
                er = cfg_err;
                repeat (cfg_req_wait) begin @(posedge clock); #1; end
                mem_req_ready = 1'b1;
                @(posedge clock); #1;
                mem_req_ready = 1'b0;
                repeat (rw) begin @(posedge clock); #1; end
                mem_rsp_valid = 1'b1;
                mem_rsp_err   = er;
                mem_rsp_data  = er ? ($urandom() | 32'h1) : mem_word(ba);
                @(posedge clock); #1;
                mem_rsp_valid = 1'b0;
                mem_rsp_err   = 1'b0;
                mem_rsp_data  = '0;
            end
        end
    end

    // ----------------------------------------------------- reference model
    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } fill_t;

    exp_t        exp_q  [$];
    fill_t       fill_q [$];
    logic [31:0] mem_q  [$];

    logic              ref_valid [LINES] = '{default: 1'b0};
    logic [TAG_W-1:0]  ref_tag   [LINES] = '{default: '0};
    logic [31:0]       ref_data  [LINES] = '{default: '0};
    logic [31:0]       m_hits   = 0;
    logic [31:0]       m_misses = 0;

    function automatic bit is_unc(input logic [31:0] ba);
        return (ba & 32'hF000_0000) == 32'h1000_0000;
    endfunction

    // ------------------------------------------------- observation record
    int          fill_cnt   = 0;
    int          mem_hs_cnt = 0;
    logic [31:0] last_fill_data = '0;
    logic [31:0] last_mem_addr  = '0;
    logic [31:0] last_rsp_data  = '0;
    logic        last_rsp_err   = 1'b0;

    // ------------------------------------------------------ compare process
    initial begin : compare_proc
        bit          prev_pend;
        logic [31:0] prev_maddr;
        fill_t       f;
        exp_t        e;
        logic [31:0] m;
        prev_pend  = 1'b0;
        prev_maddr = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_pend = 1'b0;
            end else begin
                if (cache_wen) begin
                    fill_cnt++;
                    last_fill_data = cache_wdata;
                    check("fill_expected", 32'(fill_q.size() > 0), 1);
                    if (fill_q.size() > 0) begin
                        f = fill_q.pop_front();
                        check("fill_addr", 32'(cache_addr), 32'(f.addr));
                        check("fill_data", cache_wdata, f.data);
                    end
                end
                if (prev_pend) begin
                    check("mem_valid_held", 32'(mem_req_valid), 1);
                    check("mem_addr_held", mem_req_addr, prev_maddr);
                end
                if (mem_req_valid && mem_req_ready) begin
                    mem_hs_cnt++;
                    last_mem_addr = mem_req_addr;
                    check("mem_expected", 32'(mem_q.size() > 0), 1);
                    if (mem_q.size() > 0) begin
                        m = mem_q.pop_front();
                        check("mem_addr", mem_req_addr, m);
                    end
                end
                prev_pend  = mem_req_valid && !mem_req_ready;
                prev_maddr = mem_req_addr;
                if (ifu_rsp_valid) begin
                    check("req_ready_in_resp", 32'(ifu_req_ready), 0);
                    check("rsp_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        check("rsp_data", ifu_rsp_data, e.data);
                        check("rsp_err", 32'(ifu_rsp_err), 32'(e.err));
                        check("hit_cnt", hit_cnt, e.hits);
                        check("miss_cnt", miss_cnt, e.misses);
                        if (ifu_rsp_ready) begin
                            void'(exp_q.pop_front());
                            last_rsp_data = ifu_rsp_data;
                            last_rsp_err  = ifu_rsp_err;
                            check("no_pending_fill", 32'(fill_q.size()), 0);
                            check("no_pending_mem", 32'(mem_q.size()), 0);
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------- driver tasks
    task automatic fetch(input logic [31:0] baddr, input bit err, input int req_wait,
                         input int rsp_wait, input bit rst_in_wait, output int lat);
        logic [ADDR_W-1:0]  a;
        logic [INDEX_W-1:0] idx;
        logic [TAG_W-1:0]   tag;
        bit                 unc, hit, got;
        exp_t               e;
        fill_t              f;
        int                 cyc;
        a   = baddr[31:2];
        idx = a[INDEX_W-1:0];
        tag = a[ADDR_W-1:INDEX_W];
        unc = is_unc(baddr);
        hit = !unc && ref_valid[idx] && (ref_tag[idx] == tag);
        lat = 0;

        // Predict the outcome from the cache contents and memory image.
        if (hit) begin
            m_hits = m_hits + 1;
            e.data = ref_data[idx];
            e.err  = 1'b0;
        end else begin
            if (!unc) m_misses = m_misses + 1;
            mem_q.push_back({a, 2'b00});
            e.data = err ? 32'h0 : mem_word({a, 2'b00});
            e.err  = err;
            if (!unc && !err) begin
                f.addr = a;
                f.data = e.data;
                fill_q.push_back(f);
            end
        end
        e.hits   = m_hits;
        e.misses = m_misses;
        exp_q.push_back(e);

        cfg_req_wait = req_wait;
        cfg_rsp_wait = rsp_wait;
        cfg_err      = err;

        @(posedge clock); #1;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = a;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (ifu_req_ready) got = 1'b1;
        end
        check("req_accepted", 32'(got), 1);
        @(posedge clock); #1;
        ifu_req_valid = 1'b0;

        if (rst_in_wait) begin
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clock);
                if (mem_req_valid && mem_req_ready) got = 1'b1;
            end
            check("mem_handshake_before_reset", 32'(got), 1);
            @(posedge clock); #1;
            reset = 1'b1;
            exp_q.delete();
            fill_q.delete();
            mem_q.delete();
            m_hits   = 0;
            m_misses = 0;
            @(posedge clock); #1;
            reset = 1'b0;
            return;
        end

        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (ifu_rsp_valid) got = 1'b1;
            else cyc++;
        end
        check("rsp_seen", 32'(got), 1);
        lat = cyc + 1;
        if (hit) check("hit_latency", 32'(lat), 2);

        @(posedge clock); #1;
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        ifu_rsp_ready = 1'b1;
        @(posedge clock); #1;
        ifu_rsp_ready = 1'b0;

        if (!hit && !unc && !err) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            ref_data[idx]  = mem_word({a, 2'b00});
        end

        @(negedge clock);
        check("idle_ready", 32'(ifu_req_ready), 1);
        check("idle_hit_cnt", hit_cnt, m_hits);
        check("idle_miss_cnt", miss_cnt, m_misses);
    endtask

    // ----------------------------------------------------------- watchdog
    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // ----------------------------------------------------------- sequence
    initial begin : main
        int lat;
        int base_fill, base_mem;
        mem_img[32'h0000_0040] = 32'h0000_0013;
        mem_img[32'h1000_0000] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_req_ready", 32'(ifu_req_ready), 1);
        check("rst_rsp_valid", 32'(ifu_rsp_valid), 0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 0);
        check("rst_cache_wen", 32'(cache_wen), 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_cache_addr", 32'(cache_addr), 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_rsp_data", ifu_rsp_data, 0);

        // Cold miss.
        fetch(32'h0000_0040, 1'b0, 1, 1, 1'b0, lat);
        check("t1_mem_addr", last_mem_addr, 32'h0000_0040);
        check("t1_fill_data", last_fill_data, 32'h0000_0013);
        check("t1_fill_cnt", 32'(fill_cnt), 1);
        check("t1_rsp", last_rsp_data, 32'h0000_0013);
        check("t1_miss_cnt", miss_cnt, 1);

        // Re-fetch hits.
        base_mem = mem_hs_cnt;
        fetch(32'h0000_0040, 1'b0, 0, 0, 1'b0, lat);
        check("t2_latency", 32'(lat), 2);
        check("t2_hit_cnt", hit_cnt, 1);
        check("t2_no_mem", 32'(mem_hs_cnt - base_mem), 0);
        check("t2_rsp", last_rsp_data, 32'h0000_0013);

        // Conflict on index 0.
        fetch(32'h0000_0080, 1'b0, 0, 2, 1'b0, lat);
        fetch(32'h0000_0040, 1'b0, 2, 0, 1'b0, lat);
        check("t3_miss_cnt", miss_cnt, 3);
        check("t3_rsp", last_rsp_data, 32'h0000_0013);

        // Uncached window.
        base_fill = fill_cnt;
        base_mem  = mem_hs_cnt;
        fetch(32'h1000_0000, 1'b0, 1, 1, 1'b0, lat);
        check("t4_rsp", last_rsp_data, 32'hDEAD_BEEF);
        fetch(32'h1000_0000, 1'b0, 0, 0, 1'b0, lat);
        check("t4_no_fill", 32'(fill_cnt - base_fill), 0);
        check("t4_mem_twice", 32'(mem_hs_cnt - base_mem), 2);
        check("t4_hit_cnt", hit_cnt, 1);
        check("t4_miss_cnt", miss_cnt, 3);

        // Memory error.
        base_fill = fill_cnt;
        fetch(32'h0000_0100, 1'b1, 0, 1, 1'b0, lat);
        check("t5_rsp_err", 32'(last_rsp_err), 1);
        check("t5_rsp_data", last_rsp_data, 0);
        check("t5_no_fill", 32'(fill_cnt - base_fill), 0);
        fetch(32'h0000_0100, 1'b0, 0, 0, 1'b0, lat);
        check("t5_refetch_miss", miss_cnt, 5);

        // Backpressure then reset while waiting for the memory response.
        fetch(32'h0000_0200, 1'b0, 5, 4, 1'b1, lat);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("t6_rsp_valid", 32'(ifu_rsp_valid), 0);
            check("t6_mem_req_valid", 32'(mem_req_valid), 0);
            check("t6_req_ready", 32'(ifu_req_ready), 1);
        end
        check("t6_hit_cnt", hit_cnt, 0);
        check("t6_miss_cnt", miss_cnt, 0);

        // Randomized traffic over a small footprint so hits, conflicts,
        // uncached fetches and errors all recur.
        for (int i = 0; i < 120; i++) begin
            logic [31:0] ba;
            bit          er;
            if ($urandom_range(0, 9) == 0) begin
                ba = 32'h1000_0000 + 32'($urandom_range(0, 7)) * 4;
            end else begin
                ba = (32'($urandom_range(0, 2)) * 16 + 32'($urandom_range(0, 15))) * 4;
            end
            er = ($urandom_range(0, 9) == 0);
            fetch(ba, er, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, lat);
        end

        repeat (4) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
